alu_mc: RTL
===========

ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand and result width in bits (legal range 4..64).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  operation request present.
REQ-005 SHALL have port in_ready  output  1  block able to accept a request.
REQ-006 SHALL have port a  input  WIDTH  operand A.
REQ-007 SHALL have port b  input  WIDTH  operand B.
REQ-008 SHALL have port op  input  3  opcode.
REQ-009 SHALL have port res_valid  output  1  result and flags valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts result.
REQ-011 SHALL have port res  output  WIDTH  registered result.
REQ-012 SHALL have port zero  output  1  res == 0.
REQ-013 SHALL have port carry  output  1  carry/borrow flag.
REQ-014 SHALL have port overflow  output  1  signed-overflow flag.

Function
REQ-015 SHALL implement the FSM states IDLE, MUL and DONE, with in_ready = 1 only in IDLE.
REQ-016 SHALL accept a request when in_valid && in_ready, latching a, b and op; input changes after acceptance SHALL be ignored.
REQ-017 SHALL decode opcodes: 0 ADD, 1 SUB (a-b), 2 XOR, 3 SLTU (unsigned a<b -> 1 else 0), 4 AND, 5 OR, 6 SLT (signed a<b -> 1 else 0), 7 MUL (low WIDTH bits of a*b).
REQ-018 SHALL, for ops 0-6, move IDLE->DONE on acceptance, with res/flags registered and res_valid = 1 in the cycle after acceptance (latency 1).
REQ-019 SHALL, for op 7, move IDLE->MUL and compute by shift-add over exactly WIDTH cycles (one multiplier bit per cycle), then enter DONE; res_valid SHALL rise WIDTH+1 cycles after acceptance.
REQ-020 SHALL, in DONE, hold res, zero, carry, overflow and res_valid = 1 stable until out_ready = 1, then move to IDLE on that edge with res_valid = 0.
REQ-021 SHALL not accept a new request in the same cycle a result is drained; maximum throughput is one single-cycle op per 2 cycles.
REQ-022 SHALL wrap all arithmetic modulo 2^WIDTH.
REQ-023 SHALL set carry as: ADD = carry-out of bit WIDTH-1; SUB = borrow (1 when a<b unsigned); all other ops 0.
REQ-024 SHALL set overflow as: ADD/SUB = two's-complement signed overflow; all other ops 0.
REQ-025 SHALL compute zero from the final registered res for every op.
REQ-026 SHALL, while res_valid = 0, hold res and the flags at their last value (0 after reset).

Reset
REQ-027 SHALL, while reset = 1, immediately (asynchronously) force state IDLE, res = 0, zero = 0, carry = 0, overflow = 0, res_valid = 0, and clear the multiplier accumulator/counter.
REQ-028 SHALL discard any in-flight operation, including a MUL mid-iteration or an undrained DONE result, when reset asserts mid-operation; in_ready SHALL be 1 on the first edge after reset deasserts.

Verification
REQ-029 SHALL be verified by WIDTH=32, ADD a=0xFFFFFFFF b=1 -> after 1 cycle res=0, zero=1, carry=1, overflow=0, res_valid=1.
REQ-030 SHALL be verified by SUB a=0x80000000 b=1 -> res=0x7FFFFFFF, overflow=1, carry=0; SUB a=0 b=1 -> res=0xFFFFFFFF, carry=1.
REQ-031 SHALL be verified by SLTU a=1 b=0xFFFFFFFF -> res=1, and SLT on the same operands -> res=0.
REQ-032 SHALL be verified by MUL a=0x10000 b=0x10001 -> res_valid exactly 33 cycles after acceptance, res=0x00010000, with in_ready=0 throughout.
REQ-033 SHALL be verified by holding out_ready=0 for 5 cycles in DONE -> res/flags stable, in_ready=0, and an in_valid pulse not accepted; then out_ready=1 -> IDLE next cycle.
REQ-034 SHALL be verified by asserting reset at cycle 10 of a MUL -> outputs 0 immediately, no res_valid afterward, and a following ADD 2+3 -> res=5.

Source files
------------

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/arithmetic ops and a WIDTH-cycle shift-add multiply,
// with a valid/ready handshake and a result held until the consumer takes it.
module alu_mc #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             res_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res,
    output logic             zero,
    output logic             carry,
    output logic             overflow
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_XOR  = 3'd2;
    localparam logic [2:0] OP_SLTU = 3'd3;
    localparam logic [2:0] OP_AND  = 3'd4;
    localparam logic [2:0] OP_OR   = 3'd5;
    localparam logic [2:0] OP_SLT  = 3'd6;
    localparam logic [2:0] OP_MUL  = 3'd7;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DONE
    } state_t;

    state_t           state;
    state_t           nextState;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] accNext;
    logic [CW-1:0]    cnt;
    logic             accept;
    logic             lastStep;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] aluRes;
    logic             aluCarry;
    logic             aluOverflow;

    assign in_ready  = (state == IDLE);
    assign res_valid = (state == DONE);
    assign accept    = in_valid && in_ready;
    assign lastStep  = (cnt == CW'(WIDTH - 1));
    assign accNext   = acc + (mplier[0] ? mcand : '0);

    // Single-cycle datapath; the extra top bit of diff is the unsigned borrow (a < b).
    always_comb begin
        sum         = {1'b0, a} + {1'b0, b};
        diff        = {1'b0, a} - {1'b0, b};
        aluRes      = '0;
        aluCarry    = 1'b0;
        aluOverflow = 1'b0;
        case (op)
            OP_ADD: begin
                aluRes      = sum[WIDTH-1:0];
                aluCarry    = sum[WIDTH];
                aluOverflow = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                aluRes      = diff[WIDTH-1:0];
                aluCarry    = diff[WIDTH];
                aluOverflow = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_XOR:  aluRes = a ^ b;
            OP_SLTU: aluRes = {{(WIDTH-1){1'b0}}, diff[WIDTH]};
            OP_AND:  aluRes = a & b;
            OP_OR:   aluRes = a | b;
            OP_SLT:  aluRes = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            default: aluRes = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (accept) nextState = (op == OP_MUL) ? MUL : DONE;
            MUL:     if (lastStep) nextState = DONE;
            DONE:    if (out_ready) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Results only change on acceptance of a single-cycle op or on the final multiply step,
    // so res and the flags naturally hold their last value while res_valid is low.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mcand    <= '0;
            mplier   <= '0;
            acc      <= '0;
            cnt      <= '0;
            res      <= '0;
            zero     <= 1'b0;
            carry    <= 1'b0;
            overflow <= 1'b0;
        end else if (accept && (op == OP_MUL)) begin
            mcand  <= a;
            mplier <= b;
            acc    <= '0;
            cnt    <= '0;
        end else if (accept) begin
            res      <= aluRes;
            zero     <= (aluRes == '0);
            carry    <= aluCarry;
            overflow <= aluOverflow;
        end else if (state == MUL) begin
            acc    <= accNext;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CW'(1);
            if (lastStep) begin
                res      <= accNext;
                zero     <= (accNext == '0);
                carry    <= 1'b0;
                overflow <= 1'b0;
            end
        end
    end

endmodule
